// File: rtl/adam_aes_seq_pkg.sv
// Shared definitions for the AES peripheral sequencer: register map,
// control/status bit constants and the sequencer state encoding.
package adam_aes_seq_pkg;

   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_CONFIG = 8'h08;
   localparam logic [7:0] ADDR_ER     = 8'h0C;
   localparam logic [7:0] ADDR_KEY    = 8'h14;
   localparam logic [7:0] ADDR_BLOCK  = 8'h18;
   localparam logic [7:0] ADDR_RESULT = 8'h1C;

   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_ENABLE_BIT = 1;
   localparam int ER_DONE_BIT     = 0;

   localparam logic [31:0] CTRL_ENABLE_ONLY = 32'h2;
   localparam logic [31:0] CTRL_START_EN    = 32'h3;
   localparam logic [31:0] ER_DONE_W1C      = 32'h1;

   typedef enum logic [3:0] {
      IDLE,
      CFG_CTRL,
      CFG_CONFIG,
      CFG_KEY,
      BLK_CLR,
      BLK_WR,
      START,
      POLL,
      RES_RD,
      OUT
   } state_t;

endpackage

// File: rtl/adam_aes_seq.sv
// Bus-master sequencer that streams 128-bit blocks through one AES
// peripheral: key/config programming, block write, start, poll, result read.
import adam_aes_seq_pkg::*;

module adam_aes_seq #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         cfg_encdec,
   input  logic         cfg_keylen,
   input  logic [255:0] cfg_key,
   input  logic         key_load,
   output logic         key_loaded,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_block,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_block,
   output logic         busy,
   output logic         err_timeout,
   output logic         bus_cs,
   output logic         bus_we,
   output logic [7:0]   bus_addr,
   output logic [31:0]  bus_wdata,
   input  logic [31:0]  bus_rdata
);

   state_t            state, state_nx;
   logic [2:0]        beat;
   logic [TO_W-1:0]   to_cnt;
   logic              encdec_q, keylen_q;
   logic [255:0]      key_q;
   logic [127:0]      blk_q;
   logic              done, to_last;

   assign done     = bus_rdata[ER_DONE_BIT];
   assign to_last  = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign busy     = (state != IDLE);
   assign in_ready = (state == IDLE) && key_loaded && !key_load;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:       if (key_load)                state_nx = CFG_CTRL;
                     else if (in_valid && in_ready) state_nx = BLK_CLR;
         CFG_CTRL:   state_nx = CFG_CONFIG;
         CFG_CONFIG: state_nx = CFG_KEY;
         CFG_KEY:    if (beat == 3'd7) state_nx = IDLE;
         BLK_CLR:    state_nx = BLK_WR;
         BLK_WR:     if (beat == 3'd3) state_nx = START;
         START:      state_nx = POLL;
         POLL:       if (done)         state_nx = RES_RD;
                     else if (to_last) state_nx = IDLE;
         RES_RD:     if (beat == 3'd3) state_nx = OUT;
         OUT:        if (out_ready)    state_nx = IDLE;
         default:    state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus_cs    = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = 8'h00;
      bus_wdata = 32'h0;
      out_valid = 1'b0;
      case (state)
         CFG_CTRL:   begin bus_cs = 1'b1; bus_we = 1'b1; bus_addr = ADDR_CTRL;   bus_wdata = CTRL_ENABLE_ONLY; end
         CFG_CONFIG: begin bus_cs = 1'b1; bus_we = 1'b1; bus_addr = ADDR_CONFIG; bus_wdata = {30'b0, keylen_q, encdec_q}; end
         CFG_KEY:    begin bus_cs = 1'b1; bus_we = 1'b1; bus_addr = ADDR_KEY;    bus_wdata = key_q[255 - 32*int'(beat) -: 32]; end
         BLK_CLR:    begin bus_cs = 1'b1; bus_we = 1'b1; bus_addr = ADDR_ER;     bus_wdata = ER_DONE_W1C; end
         BLK_WR:     begin bus_cs = 1'b1; bus_we = 1'b1; bus_addr = ADDR_BLOCK;  bus_wdata = blk_q[127 - 32*int'(beat[1:0]) -: 32]; end
         START:      begin bus_cs = 1'b1; bus_we = 1'b1; bus_addr = ADDR_CTRL;   bus_wdata = CTRL_START_EN; end
         POLL:       begin bus_cs = 1'b1; bus_addr = ADDR_ER; end
         RES_RD:     begin bus_cs = 1'b1; bus_addr = ADDR_RESULT; end
         OUT:        out_valid = 1'b1;
         default:    ;
      endcase
   end

   // Beat restarts on every state change so multi-beat states always begin at word 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         beat        <= '0;
         to_cnt      <= '0;
         encdec_q    <= 1'b0;
         keylen_q    <= 1'b0;
         key_q       <= '0;
         blk_q       <= '0;
         out_block   <= '0;
         key_loaded  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         beat <= (state_nx != state) ? 3'd0 : beat + 3'd1;

         if (state == START)             to_cnt <= '0;
         else if (state == POLL && !done) to_cnt <= to_cnt + 1'b1;

         if (state == IDLE && key_load) begin
            encdec_q    <= cfg_encdec;
            keylen_q    <= cfg_keylen;
            key_q       <= cfg_key;
            err_timeout <= 1'b0;
            key_loaded  <= 1'b0;
         end
         if (state == CFG_KEY && beat == 3'd7) key_loaded <= 1'b1;

         if (in_valid && in_ready) blk_q <= in_block;

         if (state == POLL && !done && to_last) err_timeout <= 1'b1;

         if (state == RES_RD) out_block[127 - 32*int'(beat[1:0]) -: 32] <= bus_rdata;
      end
   end

endmodule

// File: tb/tb_adam_aes_seq.sv
// Directed bench for adam_aes_seq with a behavioural AES peripheral register model
// that answers known FIPS-197 vectors and a fixed XOR pattern otherwise.
module tb_adam_aes_seq;
   import adam_aes_seq_pkg::*;

   localparam int TO = 16;
   localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] XPAT  = {4{32'hA5A5A5A5}};

   logic clk = 1'b0, reset_n = 1'b0;
   logic cfg_encdec = 1'b0, cfg_keylen = 1'b0, key_load = 1'b0;
   logic [255:0] cfg_key = '0;
   logic in_valid = 1'b0, out_ready = 1'b0;
   logic [127:0] in_block = '0;
   logic key_loaded, in_ready, out_valid, busy, err_timeout;
   logic [127:0] out_block;
   logic bus_cs, bus_we;
   logic [7:0] bus_addr;
   logic [31:0] bus_wdata, bus_rdata;

   always #5 clk = ~clk;

   adam_aes_seq #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n),
      .cfg_encdec(cfg_encdec), .cfg_keylen(cfg_keylen), .cfg_key(cfg_key),
      .key_load(key_load), .key_loaded(key_loaded),
      .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
      .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
      .busy(busy), .err_timeout(err_timeout),
      .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
   );

   // ---------------- peripheral model ----------------
   int poll_lat = 2;
   logic never_done = 1'b0;
   logic [255:0] key_w;
   logic [127:0] blk_w, res;
   logic [1:0] cfg_r, bptr, rptr;
   logic [2:0] kptr;
   logic started;
   int dcnt, er_reads, key_writes, blk_writes, ov_cnt;

   function automatic logic [127:0] lookup(input logic [255:0] k, input logic [1:0] c, input logic [127:0] b);
      if (c == 2'b01 && k == K128 && b == PT)    return CT128;
      if (c == 2'b11 && k == K256 && b == PT)    return CT256;
      if (c == 2'b10 && k == K256 && b == CT256) return PT;
      return b ^ XPAT;
   endfunction

   always_comb begin
      bus_rdata = '0;
      res = lookup(key_w, cfg_r, blk_w);
      if (bus_cs && !bus_we) begin
         if (bus_addr == ADDR_ER) bus_rdata = {31'b0, started && dcnt == 0 && !never_done};
         else if (bus_addr == ADDR_RESULT) bus_rdata = res[127 - 32*int'(rptr) -: 32];
      end
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_w <= '0; blk_w <= '0; cfg_r <= '0; bptr <= '0; rptr <= '0; kptr <= '0;
         started <= 1'b0; dcnt <= 0; er_reads <= 0; key_writes <= 0; blk_writes <= 0; ov_cnt <= 0;
      end else begin
         if (out_valid) ov_cnt <= ov_cnt + 1;
         if (started && dcnt != 0) dcnt <= dcnt - 1;
         if (bus_cs && bus_we) begin
            case (bus_addr)
               ADDR_CTRL:   if (bus_wdata[0]) begin started <= 1'b1; dcnt <= poll_lat; end
               ADDR_CONFIG: cfg_r <= bus_wdata[1:0];
               ADDR_ER:     if (bus_wdata[0]) started <= 1'b0;
               ADDR_KEY:    begin key_w[255 - 32*int'(kptr) -: 32] <= bus_wdata; kptr <= kptr + 3'd1; key_writes <= key_writes + 1; end
               ADDR_BLOCK:  begin blk_w[127 - 32*int'(bptr) -: 32] <= bus_wdata; bptr <= bptr + 2'd1; blk_writes <= blk_writes + 1; end
               default: ;
            endcase
         end else if (bus_cs) begin
            if (bus_addr == ADDR_ER)     er_reads <= er_reads + 1;
            if (bus_addr == ADDR_RESULT) rptr <= rptr + 2'd1;
         end
      end
   end

   // ---------------- checking helpers ----------------
   int tests = 0, fails = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_key(input logic enc, input logic klen, input logic [255:0] k, input string tag);
      int n, kw0;
      n = 0;
      while (busy && n < 200) begin tick(); n++; end
      kw0 = key_writes;
      cfg_encdec = enc; cfg_keylen = klen; cfg_key = k; key_load = 1'b1;
      tick();
      key_load = 1'b0;
      n = 0;
      while (!key_loaded && n < 50) begin tick(); n++; end
      chk({tag, "_key_lat"}, n, 10);
      chk({tag, "_key_writes"}, key_writes - kw0, 8);
      chk({tag, "_key_words"}, key_w, k);
   endtask

   task automatic do_block(input logic [127:0] b, input logic [127:0] exp, input int lat,
                           input int stall, input string tag);
      int n, bw0, er0;
      logic ok;
      poll_lat = lat;
      n = 0;
      while (!in_ready && n < 200) begin tick(); n++; end
      chk({tag, "_in_ready"}, in_ready, 1);
      bw0 = blk_writes; er0 = er_reads;
      in_valid = 1'b1; in_block = b;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin tick(); n++; end
      chk({tag, "_latency"}, n, 10 + lat + 1);
      chk({tag, "_blk_writes"}, blk_writes - bw0, 4);
      chk({tag, "_blk_words"}, blk_w, b);
      chk({tag, "_er_reads"}, er_reads - er0, lat + 1);
      chk({tag, "_out_block"}, out_block, exp);
      ok = 1'b1;
      for (int i = 0; i < stall; i++) begin
         tick();
         if (out_block !== exp || !out_valid || in_ready) ok = 1'b0;
      end
      if (stall > 0) chk({tag, "_stall_stable"}, ok, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_post_hs"}, {out_valid, busy, in_ready}, 3'b001);
   endtask

   localparam logic [174:0] ZERO_OUTS = '0;

   initial begin
      int n, kw0, bw0, er0, ov0;
      logic err_sample, inr_sample;

      // reset state
      #12;
      chk("reset_outputs", {bus_cs, bus_we, bus_addr, bus_wdata, out_valid, out_block,
                            busy, key_loaded, in_ready, err_timeout}, ZERO_OUTS);
      @(negedge clk); reset_n = 1'b1;
      tick();

      // AES-128 encrypt
      do_key(1'b1, 1'b0, K128, "k128");
      chk("k128_words4to7_zero", key_w[127:0], 128'h0);
      do_block(PT, CT128, 2, 0, "aes128");

      // AES-256 encrypt, then decrypt with reloaded config
      do_key(1'b1, 1'b1, K256, "k256e");
      do_block(PT, CT256, 1, 0, "aes256e");
      do_key(1'b0, 1'b1, K256, "k256d");
      chk("k256d_cfg", cfg_r, 2'b10);
      do_block(CT256, PT, 3, 0, "aes256d");

      // streaming, block 2 stalled 5 cycles
      do_block(128'h0123456789abcdef_fedcba9876543210, 128'h0123456789abcdef_fedcba9876543210 ^ XPAT, 0, 0, "strm1");
      do_block(128'hdeadbeef_cafef00d_12345678_9abcdef0, 128'hdeadbeef_cafef00d_12345678_9abcdef0 ^ XPAT, 2, 5, "strm2");
      do_block(128'hffffffff_00000000_ffffffff_00000000, 128'hffffffff_00000000_ffffffff_00000000 ^ XPAT, 1, 0, "strm3");

      // timeout
      never_done = 1'b1;
      er0 = er_reads; ov0 = ov_cnt;
      in_valid = 1'b1; in_block = PT;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (busy && n < 100) begin tick(); n++; end
      chk("to_er_reads", er_reads - er0, TO);
      chk("to_err", err_timeout, 1);
      chk("to_no_out", ov_cnt - ov0, 0);
      chk("to_idle", busy, 0);
      never_done = 1'b0;
      cfg_encdec = 1'b1; cfg_keylen = 1'b0; cfg_key = K128; key_load = 1'b1;
      tick();
      key_load = 1'b0;
      chk("to_err_cleared", err_timeout, 0);
      n = 0;
      while (!key_loaded && n < 50) begin tick(); n++; end
      chk("to_reload_done", key_loaded, 1);

      // simultaneous key_load and in_valid
      kw0 = key_writes; bw0 = blk_writes;
      key_load = 1'b1; in_valid = 1'b1; in_block = 128'h1;
      #1 inr_sample = in_ready;
      chk("sim_in_ready_low", inr_sample, 0);
      tick();
      key_load = 1'b0; in_valid = 1'b0;
      chk("sim_cfg_ctrl", {busy, bus_cs, bus_we, bus_addr, bus_wdata}, {3'b111, ADDR_CTRL, CTRL_ENABLE_ONLY});
      n = 0;
      while (!key_loaded && n < 50) begin tick(); n++; end
      chk("sim_key_writes", key_writes - kw0, 8);
      chk("sim_no_block", blk_writes - bw0, 0);

      // key_load during POLL is ignored
      poll_lat = 5;
      kw0 = key_writes;
      in_valid = 1'b1; in_block = PT;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!(bus_cs && !bus_we && bus_addr == ADDR_ER) && n < 50) begin tick(); n++; end
      cfg_encdec = 1'b0; cfg_key = K256; key_load = 1'b1;
      tick();
      key_load = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin tick(); n++; end
      chk("poll_kl_result", out_block, CT128);
      chk("poll_kl_no_keywr", key_writes - kw0, 0);
      chk("poll_kl_loaded", key_loaded, 1);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // reset during RES_RD beat 2
      poll_lat = 1;
      in_valid = 1'b1; in_block = PT;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!(bus_cs && bus_addr == ADDR_RESULT) && n < 50) begin tick(); n++; end
      tick(); tick();
      chk("rst_at_beat2", {bus_cs, bus_we, bus_addr, rptr}, {2'b10, ADDR_RESULT, 2'd2});
      reset_n = 1'b0;
      #1;
      err_sample = err_timeout;
      chk("rst_async_outputs", {bus_cs, bus_we, bus_addr, bus_wdata, out_valid, out_block,
                                busy, key_loaded, in_ready, err_sample}, ZERO_OUTS);
      @(negedge clk); reset_n = 1'b1;
      tick();
      do_key(1'b1, 1'b0, K128, "rst_k128");
      do_block(PT, CT128, 2, 0, "rst_aes128");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
